// File: rtl/dmem_port_arbiter.sv
// Data memory port arbiter: CPU execute stage has fixed priority over the
// host/debug port, with a starvation counter that forces one host slot
// (stalling the CPU) after MAX_WAIT consecutive lost cycles.
module dmem_port_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        NORMAL    = 1'b0,
        HOST_SLOT = 1'b1
    } slot_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    slot_t      slot;
    slot_t      slot_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;
    logic [3:0] wait_inc;
    logic       host_sel;
    logic       contend;

    // Port mux: host wins when the CPU is idle or a forced slot is active;
    // everything that can touch memory or the pipeline is gated by reset.
    always_comb begin
        host_sel  = reset && host_req && ((slot == HOST_SLOT) || !cpu_req);
        host_gnt  = host_sel;
        cpu_stall = cpu_req && host_sel;
        cpu_rdata = mem_rdata;
        if (host_sel) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = reset && cpu_req && cpu_we;
        end
    end

    // Starvation counter and slot next-state; a forced slot lasts one cycle
    // and is simply lost if the host withdrew its request meanwhile.
    always_comb begin
        contend  = host_req && cpu_req && !host_sel;
        wait_inc = (wait_cnt >= MAX_CNT) ? wait_cnt : wait_cnt + 4'd1;
        wait_nxt = contend ? wait_inc : 4'd0;
        slot_nxt = NORMAL;
        if ((slot == NORMAL) && contend && (wait_inc == MAX_CNT)) begin
            slot_nxt = HOST_SLOT;
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot     <= NORMAL;
            wait_cnt <= 4'd0;
        end else begin
            slot     <= slot_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Host read return: capture memory data on a granted read, valid one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= host_sel && !host_we;
            if (host_sel && !host_we) begin
                host_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small synchronous-write,
// combinational-read memory attached to the memory port.
module tb_dmem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_stall;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [256];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_W(8), .ADDR_W(8), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                         input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    // Advance to just after the next rising edge, then apply new inputs.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        #2;
        check("rst_gnt",    host_gnt, 1'b0);
        check("rst_stall",  cpu_stall, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_rvalid", host_rvalid, 1'b0);
        check("rst_rdata",  host_rdata, 8'h00);
        check("rst_wait",   dut.wait_cnt, 4'd0);
        // Requests during reset must not reach memory
        drive(1, 1, 8'h10, 8'hEE, 1, 1, 8'h20, 8'hEE);
        #1;
        check("rst_req_mem_we", mem_we, 1'b0);
        check("rst_req_gnt",    host_gnt, 1'b0);
        @(negedge clk);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        reset = 1'b1;

        // Host preload with idle CPU: granted same cycle
        next_cycle();
        drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C);
        #1;
        check("hw_gnt",   host_gnt, 1'b1);
        check("hw_we",    mem_we, 1'b1);
        check("hw_addr",  mem_addr, 8'h20);
        check("hw_wdata", mem_wdata, 8'h3C);

        // CPU write, no contention
        next_cycle();
        drive(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
        #1;
        check("cw_we",    mem_we, 1'b1);
        check("cw_addr",  mem_addr, 8'h10);
        check("cw_wdata", mem_wdata, 8'hA5);
        check("cw_stall", cpu_stall, 1'b0);
        check("cw_gnt",   host_gnt, 1'b0);
        check("cw_rvalid_after_hw", host_rvalid, 1'b0);

        // Host read at 0x20 with idle CPU
        next_cycle();
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
        #1;
        check("hr_gnt", host_gnt, 1'b1);
        check("hr_we",  mem_we, 1'b0);
        check("hr_addr", mem_addr, 8'h20);

        // Read data returns; CPU reads back its own write at zero latency
        next_cycle();
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        #1;
        check("hr_rvalid", host_rvalid, 1'b1);
        check("hr_rdata",  host_rdata, 8'h3C);
        check("cr_rdata",  cpu_rdata, 8'hA5);
        check("cr_stall",  cpu_stall, 1'b0);

        next_cycle();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        #1;
        check("hr_rvalid_drop", host_rvalid, 1'b0);
        check("hr_rdata_hold",  host_rdata, 8'h3C);

        // Starvation: CPU reads continuously, host write 0x55 -> 0x40
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1, 0, 8'h11, 8'h00, 1, 1, 8'h40, 8'h55);
            #1;
            check("sv_gnt",   host_gnt, 1'b0);
            check("sv_stall", cpu_stall, 1'b0);
            check("sv_addr",  mem_addr, 8'h11);
            check("sv_wait",  dut.wait_cnt, 4'(i));
        end
        next_cycle();
        #1;
        check("fs_gnt",   host_gnt, 1'b1);
        check("fs_stall", cpu_stall, 1'b1);
        check("fs_addr",  mem_addr, 8'h40);
        check("fs_we",    mem_we, 1'b1);
        check("fs_wdata", mem_wdata, 8'h55);
        next_cycle();
        drive(1, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h00);
        #1;
        check("fs_after_stall", cpu_stall, 1'b0);
        check("fs_after_wait",  dut.wait_cnt, 4'd0);
        check("fs_mem_40",      mem[8'h40], 8'h55);

        // Host withdraws during the forced slot
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1, 0, 8'h11, 8'h00, 1, 1, 8'h41, 8'hC3);
            #1;
        end
        check("wd_pre_wait", dut.wait_cnt, 4'd3);
        next_cycle();
        drive(1, 1, 8'h50, 8'h77, 0, 1, 8'h41, 8'hC3);
        #1;
        check("wd_stall", cpu_stall, 1'b0);
        check("wd_gnt",   host_gnt, 1'b0);
        check("wd_addr",  mem_addr, 8'h50);
        check("wd_we",    mem_we, 1'b1);
        check("wd_wdata", mem_wdata, 8'h77);
        next_cycle();
        drive(1, 0, 8'h11, 8'h00, 1, 1, 8'h41, 8'hC3);
        #1;
        check("wd_slot_over_gnt", host_gnt, 1'b0);
        check("wd_wait_clear",    dut.wait_cnt, 4'd0);
        check("wd_mem_50",        mem[8'h50], 8'h77);
        check("wd_mem_41",        mem[8'h41], 8'hxx);

        // Reset asserted in the middle of a forced host read slot
        next_cycle();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1, 1, 8'h60, 8'h99, 1, 0, 8'h20, 8'h00);
            #1;
        end
        next_cycle();
        #1;
        check("rs_gnt_before", host_gnt, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check("rs_gnt",   host_gnt, 1'b0);
        check("rs_we",    mem_we, 1'b0);
        check("rs_stall", cpu_stall, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        next_cycle();
        #1;
        check("rs_rvalid", host_rvalid, 1'b0);
        check("rs_wait",   dut.wait_cnt, 4'd0);

        // Alternating CPU activity with host held: host served in every idle CPU cycle
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            drive((i % 2) == 0, 0, 8'h11, 8'h00, 1, 1, 8'h70, 8'(i));
            #1;
            check("alt_gnt",   host_gnt, (i % 2) == 1);
            check("alt_stall", cpu_stall, 1'b0);
            check("alt_wait",  dut.wait_cnt, (i % 2) == 1);
        end
        next_cycle();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        #1;
        check("alt_mem_70", mem[8'h70], 8'h07);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Arbitrates the single-port 8-bit data memory between two requesters:
  - the CPU execute stage;
  - a host/debug port used for loading and inspecting data memory.
- CPU has fixed priority.
- A starvation counter forces a host slot after MAX_WAIT lost cycles; the CPU pipeline is stalled for that one slot.
- Sits between the execute stage and the data memory; memory writes are synchronous and reads are combinational.

Parameters:
- DATA_W, 8, data width of memory and both requesters
- ADDR_W, 8, address width
- MAX_WAIT, 4, consecutive lost cycles before the host is forced a slot (legal range 1..15)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU memory access this cycle
- cpu_we  input  1  CPU write (1) / read (0)
- cpu_addr  input  ADDR_W  CPU address
- cpu_wdata  input  DATA_W  CPU write data
- cpu_rdata  output  DATA_W  read data to CPU (mem_rdata pass-through)
- cpu_stall  output  1  CPU access not served; pipeline must hold
- host_req  input  1  host access request, held until granted
- host_we  input  1  host write/read
- host_addr  input  ADDR_W  host address
- host_wdata  input  DATA_W  host write data
- host_gnt  output  1  host access performed this cycle
- host_rvalid  output  1  registered host read data valid
- host_rdata  output  DATA_W  registered host read data
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data (combinational from mem_addr)

Behaviour:
- State register `slot`: NORMAL or HOST_SLOT.
- Counter `wait_cnt`: 4 bits, saturating at MAX_WAIT.

Reset (reset low, asynchronous):
- slot=NORMAL, wait_cnt=0, host_rvalid=0, host_rdata=0.
- While reset is low: host_gnt=0, cpu_stall=0, mem_we=0.

Host selection (combinational, `host_sel`):
- host_sel = host_req AND (slot==HOST_SLOT OR cpu_req==0).
- host_sel=1: mem_addr/mem_wdata taken from host; mem_we=host_we; host_gnt=1.
- host_sel=0: mem_addr/mem_wdata taken from CPU; mem_we=cpu_req AND cpu_we; host_gnt=0.

CPU stall and read data:
- cpu_stall = cpu_req AND host_sel.
- cpu_rdata = mem_rdata at all times; valid only when cpu_req=1 and cpu_stall=0.

Counter (evaluated at each rising edge):
- host_req=1 AND cpu_req=1 AND host_sel=0: wait_cnt increments, saturating.
- host_sel=1 or host_req=0: wait_cnt clears to 0.

Slot transitions:
- NORMAL -> HOST_SLOT when the incremented wait_cnt reaches MAX_WAIT.
- HOST_SLOT -> NORMAL unconditionally after one cycle.
- If host_req drops while in HOST_SLOT, the slot is consumed with no access: cpu not stalled, mem_we from CPU.

Host read return:
- host_rvalid <= host_sel AND NOT host_we, i.e. pulses 1 cycle after a granted read.
- host_rdata <= mem_rdata when a host read is granted; otherwise holds.

Other rules:
- Latency: host write commits at the grant edge; host read data appears one cycle after grant.
- CPU with no host contention: zero added latency, never stalled.
- Host with idle CPU: granted the same cycle as the request; back-to-back host accesses allowed every cycle.
- Simultaneous CPU and host write to the same address: only the granted requester writes; no merge.
- Reset asserted mid-HOST_SLOT: slot aborts, and a pending host read produces no rvalid.

Test Plan:
- After reset deassert, cpu_req=1, cpu_we=1, addr=0x10, wdata=0xA5 -> mem_we=1, mem_addr=0x10, cpu_stall=0, host_gnt=0.
- cpu_req=0, host read at 0x20 with mem holding 0x3C -> host_gnt=1 same cycle; next cycle host_rvalid=1, host_rdata=0x3C; then host_rvalid=0.
- cpu_req=1 continuously, host_req=1 (write 0x55 to 0x40), MAX_WAIT=4 -> host_gnt=0 for 4 cycles; 5th cycle host_gnt=1, cpu_stall=1, mem_addr=0x40, mem_we=1; 6th cycle cpu_stall=0 and wait_cnt=0.
- Host drops host_req in the cycle slot=HOST_SLOT -> cpu_stall=0, mem signals follow CPU, slot returns to NORMAL.
- Assert reset low during HOST_SLOT with a host read -> outputs immediately host_gnt=0, mem_we=0, cpu_stall=0; host_rvalid stays 0 after release.
- Alternate cpu_req 1/0 every cycle with host_req held -> host granted in every cpu_req=0 cycle, wait_cnt never exceeds 1, no forced slot.
